// File: rtl/elixirchip_es1_srl_arb_pkg.sv
// Shared types for the SPU shift-op arbiter: requester index, routing tag and stats width.
// Pure declarations; no latency.
// No flow control of its own.
package elixirchip_es1_srl_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int STAT_BITS = 16;

    // Sized for the largest supported requester count so one type serves every build.
    typedef logic [$clog2(MAX_REQ)-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } tag_t;

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer updates on the clock after a grant.
// Backpressure: no grant while cke is low or flush is high.
module elixirchip_es1_spu_rr_arbiter
    import elixirchip_es1_srl_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter     DEVICE  = "RTL"
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cke,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output idx_t               grant_idx
);

    localparam int PTR_BITS = $clog2(NUM_REQ);

    logic [PTR_BITS-1:0] ptr;
    logic [PTR_BITS-1:0] ptr_nxt;
    logic [NUM_REQ-1:0]  pick;
    logic                found;

    function automatic int wrap_idx(input int a);
        return a % NUM_REQ;
    endfunction

    always_comb begin
        pick      = '0;
        found     = 1'b0;
        grant_idx = '0;
        ptr_nxt   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[wrap_idx(int'(ptr) + k)]) begin
                found                        = 1'b1;
                pick[wrap_idx(int'(ptr) + k)] = 1'b1;
                grant_idx                    = idx_t'(wrap_idx(int'(ptr) + k));
                ptr_nxt                      = PTR_BITS'(wrap_idx(int'(ptr) + k + 1));
            end
        end
    end

    assign grant = (cke && !flush) ? pick : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (cke && !flush && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_srl_arbiter.sv
// Shares one logical-right-shift op among NUM_REQ requesters and routes results back by tag.
// Latency: accept to m_res_valid is OP_LATENCY+2 cycles; one op per enabled cycle.
// Backpressure: per-requester ready from round-robin grant; no result backpressure. Stats: ELIXIRCHIP_ES1_SRL_ARB_STATS_EN.
module elixirchip_es1_spu_srl_arbiter
    import elixirchip_es1_srl_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int SHIFT_BITS = 3,
    parameter int OP_LATENCY = 1,
    parameter     DEVICE     = "RTL"
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cke,
    input  logic                          s_flush,
    input  logic [NUM_REQ-1:0]            s_req_valid,
    output logic [NUM_REQ-1:0]            s_req_ready,
    input  logic [NUM_REQ*SHIFT_BITS-1:0] s_req_shift,
    input  logic [NUM_REQ*DATA_BITS-1:0]  s_req_data,
    output logic [SHIFT_BITS-1:0]         op_shift,
    output logic [DATA_BITS-1:0]          op_data,
    output logic                          op_clear,
    output logic                          op_valid,
    input  logic [DATA_BITS-1:0]          op_result,
    output logic [NUM_REQ-1:0]            m_res_valid,
    output logic [DATA_BITS-1:0]          m_res_data
`ifdef ELIXIRCHIP_ES1_SRL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_BITS-1:0]  grant_count
`endif
);

    logic [NUM_REQ-1:0] grant;
    idx_t               grant_idx;
    idx_t               issue_idx;
    tag_t               issue_tag;
    tag_t               exit_tag;
    logic [NUM_REQ-1:0] res_onehot;
    logic               any_grant;

    elixirchip_es1_spu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DEVICE  (DEVICE)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .cke       (cke),
        .flush     (s_flush),
        .req       (s_req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s_req_ready = grant;
    assign any_grant   = |grant;

    // Grant already excludes flush and cke=0, so idle covers the flush case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_valid  <= 1'b0;
            op_clear  <= 1'b1;
            op_shift  <= '0;
            op_data   <= '0;
            issue_idx <= '0;
        end else if (cke) begin
            if (any_grant) begin
                op_valid  <= 1'b1;
                op_clear  <= 1'b0;
                op_shift  <= s_req_shift[int'(grant_idx)*SHIFT_BITS +: SHIFT_BITS];
                op_data   <= s_req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
                issue_idx <= grant_idx;
            end else begin
                op_valid  <= 1'b0;
                op_clear  <= 1'b1;
            end
        end
    end

    assign issue_tag.valid = op_valid;
    assign issue_tag.idx   = issue_idx;

    generate
        if (OP_LATENCY == 0) begin : g_no_pipe
            assign exit_tag = issue_tag;
        end else begin : g_pipe
            tag_t pipe [OP_LATENCY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < OP_LATENCY; i++) begin
                        pipe[i] <= '0;
                    end
                end else if (cke) begin
                    if (s_flush) begin
                        for (int i = 0; i < OP_LATENCY; i++) begin
                            pipe[i] <= '0;
                        end
                    end else begin
                        pipe[0] <= issue_tag;
                        for (int i = 1; i < OP_LATENCY; i++) begin
                            pipe[i] <= pipe[i-1];
                        end
                    end
                end
            end

            assign exit_tag = pipe[OP_LATENCY-1];
        end
    endgenerate

    always_comb begin
        res_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res_onehot[i] = exit_tag.valid && (int'(exit_tag.idx) == i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_res_valid <= '0;
            m_res_data  <= '0;
        end else if (cke) begin
            if (s_flush) begin
                m_res_valid <= '0;
            end else begin
                m_res_valid <= res_onehot;
                if (exit_tag.valid) begin
                    m_res_data <= op_result;
                end
            end
        end
    end

`ifdef ELIXIRCHIP_ES1_SRL_ARB_STATS_EN
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
            logic [STAT_BITS-1:0] cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (s_req_valid[g] && grant[g]) begin
                    cnt <= sat_inc(cnt);
                end
            end

            assign grant_count[g*STAT_BITS +: STAT_BITS] = cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_srl_arbiter.sv
// Directed bench for the shared shift-op arbiter with a one-cycle shifter model.
// Inputs driven on the falling edge; outputs checked 1ns later.
module tb_elixirchip_es1_spu_srl_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cke;
    logic        s_flush;
    logic [3:0]  s_req_valid;
    logic [3:0]  s_req_ready;
    logic [11:0] s_req_shift;
    logic [31:0] s_req_data;
    logic [2:0]  op_shift;
    logic [7:0]  op_data;
    logic        op_clear;
    logic        op_valid;
    logic [7:0]  op_result;
    logic [3:0]  m_res_valid;
    logic [7:0]  m_res_data;
`ifdef ELIXIRCHIP_ES1_SRL_ARB_STATS_EN
    logic [63:0] grant_count;
`endif

    int checks = 0;
    int errors = 0;

    elixirchip_es1_spu_srl_arbiter #(
        .NUM_REQ    (4),
        .DATA_BITS  (8),
        .SHIFT_BITS (3),
        .OP_LATENCY (1),
        .DEVICE     ("RTL")
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cke         (cke),
        .s_flush     (s_flush),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_shift (s_req_shift),
        .s_req_data  (s_req_data),
        .op_shift    (op_shift),
        .op_data     (op_data),
        .op_clear    (op_clear),
        .op_valid    (op_valid),
        .op_result   (op_result),
        .m_res_valid (m_res_valid),
        .m_res_data  (m_res_data)
`ifdef ELIXIRCHIP_ES1_SRL_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    // Shifter model: one-cycle latency, same clock enable as the arbiter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_result <= '0;
        end else if (cke) begin
            op_result <= op_clear ? 8'h00 : (op_data >> op_shift);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [3:0] vld, input logic [7:0] dat);
        chk({tag, "_vld"}, 32'(m_res_valid), 32'(vld));
        if (vld != 4'b0000) chk({tag, "_dat"}, 32'(m_res_data), 32'(dat));
    endtask

    logic [3:0] gseq [5];
    logic [7:0] dseq [5];

    initial begin
        gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        dseq = '{8'h0F, 8'h52, 8'h01, 8'h1F, 8'h0F};

        reset_n     = 1'b0;
        cke         = 1'b1;
        s_flush     = 1'b0;
        s_req_valid = 4'b0000;
        // req0 F0>>4, req1 A5>>1, req2 80>>7, req3 FF>>3
        s_req_data  = {8'hFF, 8'h80, 8'hA5, 8'hF0};
        s_req_shift = {3'd3, 3'd7, 3'd1, 3'd4};

        cyc(); cyc(); #1;
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_op_clear", 32'(op_clear), 32'd1);
        chk("rst_op_data", 32'(op_data), 32'd0);
        chk("rst_op_shift", 32'(op_shift), 32'd0);
        chk("rst_res_valid", 32'(m_res_valid), 32'd0);
        chk("rst_res_data", 32'(m_res_data), 32'd0);
        reset_n = 1'b1;

        // Single request from req0.
        cyc(); s_req_valid = 4'b0001; #1;
        chk("single_rdy", 32'(s_req_ready), 32'b0001);
        cyc(); s_req_valid = 4'b0000; #1;
        chk("single_op_valid", 32'(op_valid), 32'd1);
        chk("single_op_clear", 32'(op_clear), 32'd0);
        chk("single_op_data", 32'(op_data), 32'hF0);
        chk("single_op_shift", 32'(op_shift), 32'd4);
        chk("single_rdy_idle", 32'(s_req_ready), 32'd0);
        cyc(); #1;
        chk_res("single_t2", 4'b0000, 8'h00);
        cyc(); #1;
        chk_res("single_t3", 4'b0001, 8'h0F);
        cyc(); #1;
        chk_res("single_t4", 4'b0000, 8'h00);
        chk("idle_op_valid", 32'(op_valid), 32'd0);
        chk("idle_op_clear", 32'(op_clear), 32'd1);
        chk("idle_op_data_held", 32'(op_data), 32'hF0);

        // Wrap: req2 moves ptr to 3, then req0+req3 -> 3 then 0.
        cyc(); s_req_valid = 4'b0100; #1;
        chk("wrap_rdy2", 32'(s_req_ready), 32'b0100);
        cyc(); s_req_valid = 4'b1001; #1;
        chk("wrap_rdy3", 32'(s_req_ready), 32'b1000);
        cyc(); s_req_valid = 4'b0001; #1;
        chk("wrap_rdy0", 32'(s_req_ready), 32'b0001);
        chk("wrap_op_data", 32'(op_data), 32'hFF);
        chk("wrap_op_shift", 32'(op_shift), 32'd3);
        cyc(); s_req_valid = 4'b0000; #1;
        chk_res("wrap_res2", 4'b0100, 8'h01);
        cyc(); #1;
        chk_res("wrap_res3", 4'b1000, 8'h1F);
        cyc(); #1;
        chk_res("wrap_res0", 4'b0001, 8'h0F);

        // Bring ptr to 0 via req3.
        cyc(); s_req_valid = 4'b1000; #1;
        chk("park_rdy3", 32'(s_req_ready), 32'b1000);
        cyc(); s_req_valid = 4'b0000;
        cyc(); cyc(); #1;
        chk_res("park_res3", 4'b1000, 8'h1F);

        // All four continuously valid.
        for (int k = 0; k < 8; k++) begin
            cyc();
            s_req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("all_rdy%0d", k), 32'(s_req_ready), (k < 5) ? 32'(gseq[k]) : 32'd0);
            if (k >= 3) chk_res($sformatf("all_res%0d", k), gseq[k-3], dseq[k-3]);
            else        chk_res($sformatf("all_res%0d", k), 4'b0000, 8'h00);
        end

        // Flush one cycle after accepting req2 (ptr=1).
        cyc(); s_req_valid = 4'b0100; #1;
        chk("fl_rdy2", 32'(s_req_ready), 32'b0100);
        cyc(); s_req_valid = 4'b0010; s_flush = 1'b1; #1;
        chk("fl_rdy_blocked", 32'(s_req_ready), 32'd0);
        chk("fl_op_valid_pre", 32'(op_valid), 32'd1);
        cyc(); s_flush = 1'b0; #1;
        chk("fl_rdy1", 32'(s_req_ready), 32'b0010);
        chk("fl_op_valid_cleared", 32'(op_valid), 32'd0);
        cyc(); s_req_valid = 4'b0000; #1;
        chk_res("fl_no_res2", 4'b0000, 8'h00);
        chk("fl_op_data1", 32'(op_data), 32'hA5);
        cyc(); #1;
        chk_res("fl_t4", 4'b0000, 8'h00);
        cyc(); #1;
        chk_res("fl_res1", 4'b0010, 8'h52);
        cyc(); #1;
        chk_res("fl_t6", 4'b0000, 8'h00);

        // Clock-enable freeze mid-flight (ptr=2).
        cyc(); s_req_valid = 4'b0100; #1;
        chk("ck_rdy2", 32'(s_req_ready), 32'b0100);
        cyc(); s_req_valid = 4'b0000; cke = 1'b0; #1;
        chk("ck_op_valid", 32'(op_valid), 32'd1);
        cyc(); s_req_valid = 4'b0001; #1;
        chk("ck_rdy_frozen", 32'(s_req_ready), 32'd0);
        chk("ck_op_data_f1", 32'(op_data), 32'h80);
        chk_res("ck_res_f1", 4'b0000, 8'h00);
        cyc(); #1;
        chk("ck_op_valid_f2", 32'(op_valid), 32'd1);
        chk_res("ck_res_f2", 4'b0000, 8'h00);
        cyc(); cke = 1'b1; #1;
        chk("ck_rdy0", 32'(s_req_ready), 32'b0001);
        chk("ck_op_data_f3", 32'(op_data), 32'h80);
        chk_res("ck_res_f3", 4'b0000, 8'h00);
        cyc(); s_req_valid = 4'b0000; #1;
        chk("ck_op_data0", 32'(op_data), 32'hF0);
        chk_res("ck_res_pre", 4'b0000, 8'h00);
        cyc(); #1;
        chk_res("ck_res2", 4'b0100, 8'h01);
        cyc(); #1;
        chk_res("ck_res0", 4'b0001, 8'h0F);

        // Reset pulse with req1 in flight (ptr=1).
        cyc(); s_req_valid = 4'b0010; #1;
        chk("rs_rdy1", 32'(s_req_ready), 32'b0010);
        cyc(); s_req_valid = 4'b0000; #1;
        chk("rs_op_valid", 32'(op_valid), 32'd1);
        reset_n = 1'b0;
        cyc(); #1;
        chk("rs_op_valid_clr", 32'(op_valid), 32'd0);
        chk("rs_op_clear", 32'(op_clear), 32'd1);
        chk("rs_op_data", 32'(op_data), 32'd0);
        chk_res("rs_res_clr", 4'b0000, 8'h00);
`ifdef ELIXIRCHIP_ES1_SRL_ARB_STATS_EN
        chk("rs_cnt_lo", grant_count[31:0], 32'd0);
        chk("rs_cnt_hi", grant_count[63:32], 32'd0);
`endif
        cyc(); reset_n = 1'b1; #1;
        chk_res("rs_t1", 4'b0000, 8'h00);
        cyc(); s_req_valid = 4'b1111; #1;
        chk("rs_rdy_ptr0", 32'(s_req_ready), 32'b0001);
        chk_res("rs_t2", 4'b0000, 8'h00);
        cyc(); s_req_valid = 4'b0000; #1;
        chk_res("rs_t3", 4'b0000, 8'h00);
        cyc(); #1;
        chk_res("rs_t4", 4'b0000, 8'h00);
        cyc(); #1;
        chk_res("rs_res0", 4'b0001, 8'h0F);

`ifdef ELIXIRCHIP_ES1_SRL_ARB_STATS_EN
        chk("st_cnt0_one", 32'(grant_count[15:0]), 32'd1);
        cyc(); s_req_valid = 4'b0001;
        repeat (100) cyc();
        #1;
        chk("st_cnt0_101", 32'(grant_count[15:0]), 32'd101);
        repeat (65500) cyc();
        #1;
        chk("st_cnt0_sat", 32'(grant_count[15:0]), 32'hFFFF);
        chk("st_cnt1_zero", 32'(grant_count[31:16]), 32'd0);
        cyc(); s_req_valid = 4'b0000;
`endif

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
